// File: rtl/pe_pkg.sv
// Shared constants and FSM encoding for the serial_pe sequencer slice.
package pe_pkg;

  localparam int unsigned PE_LANES  = 32;
  localparam int unsigned PE_DW     = 16;
  localparam int unsigned PE_RW     = 32;
  localparam int unsigned CTL_FIRST = 0;
  localparam int unsigned CTL_LAST  = 1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } seq_state_e;

endpackage

// File: rtl/pe_res_fifo.sv
// Synchronous result FIFO; push and pop may share a cycle even when full.
module pe_res_fifo
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [PE_RW-1:0]         data_i,
  input  logic                     pop_i,
  output logic [PE_RW-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PE_RW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot being written, so a full FIFO still accepts a push then.
  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Instruction sequencer for one serial_pe: address generation, PE strobes,
// and credit-limited result collection.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_addr,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [7:0]        inst_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] neuron_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              pe_vld,
  output logic [1:0]        pe_ctl,
  input  logic              pe_vld_o,
  input  logic [PE_RW-1:0]  pe_result,
  output logic              res_valid,
  output logic [PE_RW-1:0]  res_data,
  input  logic              res_ready,
  output logic              busy,
  output logic [1:0]        err
);

  localparam int unsigned OW = $clog2(RES_DEPTH) + 1;

  seq_state_e        state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        blk_q, blk_d;
  logic [4:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] n_addr_q, n_addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              pe_vld_q;
  logic [1:0]        pe_ctl_q, pe_ctl_d;
  logic [1:0]        err_q, err_d;

  logic              last_beat, first_beat;
  logic              accept, accept_run, accept_zero;
  logic              res_pop, res_full, res_empty;
  logic [PE_RW-1:0]  fifo_head;
  logic [$clog2(RES_DEPTH):0] res_count;

  assign accept      = inst_valid & inst_ready;
  assign accept_run  = accept & (inst_len != 8'd0);
  assign accept_zero = accept & (inst_len == 8'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: an accept on the last beat chains straight into RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept_run) state_d = ST_RUN;
      ST_RUN:  if (last_beat)  state_d = accept_run ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rd     = (state_q == ST_RUN);
    last_beat  = mem_rd & (blk_q == len_q - 8'd1) & (elem_q == 5'(PE_LANES - 1));
    first_beat = mem_rd & (blk_q == 8'd0) & (elem_q == 5'd0);
    inst_ready = ((state_q == ST_IDLE) | last_beat) & (outst_q < OW'(RES_DEPTH));
  end

  assign res_pop = res_valid & res_ready;
  assign busy    = mem_rd | pe_vld_q | (outst_q != '0);

  always_comb begin
    len_d    = len_q;
    blk_d    = blk_q;
    elem_d   = elem_q;
    n_addr_d = n_addr_q;
    w_addr_d = w_addr_q;
    outst_d  = outst_q;
    err_d    = err_q;
    pe_ctl_d = '0;

    if (accept_run) begin
      len_d  = inst_len;
      blk_d  = '0;
      elem_d = '0;
    end else if (mem_rd) begin
      elem_d = elem_q + 5'd1;
      if (elem_q == 5'(PE_LANES - 1)) blk_d = blk_q + 8'd1;
    end

    if (mem_rd) begin
      n_addr_d = n_addr_q + ADDR_W'(1);
      w_addr_d = w_addr_q + ADDR_W'(1);
    end else if (clr_addr & ~busy) begin
      n_addr_d = '0;
      w_addr_d = '0;
    end

    // Decrement is guarded: results captured after a reset carry no credit.
    unique case ({accept_run, res_pop & (outst_q != '0)})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    if (accept_zero)                     err_d[0] = 1'b1;
    if (pe_vld_o & res_full & ~res_pop)  err_d[1] = 1'b1;

    pe_ctl_d[CTL_FIRST] = first_beat;
    pe_ctl_d[CTL_LAST]  = last_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      blk_q    <= '0;
      elem_q   <= '0;
      n_addr_q <= '0;
      w_addr_q <= '0;
      outst_q  <= '0;
      err_q    <= '0;
      pe_vld_q <= 1'b0;
      pe_ctl_q <= '0;
    end else begin
      len_q    <= len_d;
      blk_q    <= blk_d;
      elem_q   <= elem_d;
      n_addr_q <= n_addr_d;
      w_addr_q <= w_addr_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      pe_vld_q <= mem_rd;
      pe_ctl_q <= pe_ctl_d;
    end
  end

  pe_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pe_vld_o),
    .data_i  (pe_result),
    .pop_i   (res_pop),
    .data_o  (fifo_head),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_count)
  );

  assign neuron_addr = n_addr_q;
  assign weight_addr = w_addr_q;
  assign pe_vld      = pe_vld_q;
  assign pe_ctl      = pe_ctl_q;
  assign err         = err_q;
  assign res_valid   = ~res_empty;
  assign res_data    = (res_count != '0) ? fifo_head : '0;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a behavioural PE that answers one
// cycle after each last beat.
module tb_pe_seq_ctrl;

  localparam int unsigned RES_DEPTH = 4;
  localparam int unsigned ADDR_W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr_addr = 1'b0;
  logic              inst_valid = 1'b0;
  logic              inst_ready;
  logic [7:0]        inst_len = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] neuron_addr, weight_addr;
  logic              pe_vld;
  logic [1:0]        pe_ctl;
  logic              pe_vld_o = 1'b0;
  logic [31:0]       pe_result = '0;
  logic              res_valid;
  logic [31:0]       res_data;
  logic              res_ready = 1'b0;
  logic              busy;
  logic [1:0]        err;

  pe_seq_ctrl #(
    .RES_DEPTH (RES_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr_addr    (clr_addr),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_len    (inst_len),
    .mem_rd      (mem_rd),
    .neuron_addr (neuron_addr),
    .weight_addr (weight_addr),
    .pe_vld      (pe_vld),
    .pe_ctl      (pe_ctl),
    .pe_vld_o    (pe_vld_o),
    .pe_result   (pe_result),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // PE model: result one cycle after the last-beat strobe
  logic [31:0] pe_next_res = '0;
  always @(posedge clk) begin
    #1;
    if (pe_vld && pe_ctl[1]) begin
      pe_vld_o    = 1'b1;
      pe_result   = pe_next_res;
      pe_next_res = pe_next_res + 32'd1;
    end else begin
      pe_vld_o  = 1'b0;
      pe_result = '0;
    end
  end

  // Monitor
  int unsigned       cyc = 0;
  int                vld_cnt, first_cyc, last_cyc, n_first, n_last, coincide, rd_cnt, addr_err;
  int                first_pos[8];
  int                last_pos[8];
  logic [ADDR_W-1:0] mon_addr = '0;
  logic [31:0]       popped[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        if (neuron_addr !== mon_addr || weight_addr !== mon_addr) addr_err++;
        mon_addr = mon_addr + ADDR_W'(1);
        rd_cnt++;
      end
      if (pe_vld) begin
        if (vld_cnt == 0) first_cyc = int'(cyc);
        last_cyc = int'(cyc);
        if (pe_ctl[0]) begin
          if (n_first < 8) first_pos[n_first] = vld_cnt;
          n_first++;
        end
        if (pe_ctl[1]) begin
          if (n_last < 8) last_pos[n_last] = vld_cnt;
          n_last++;
        end
        if (pe_ctl == 2'b11) coincide++;
        vld_cnt++;
      end
      if (res_valid && res_ready) popped.push_back(res_data);
    end
  end

  task automatic clear_mon();
    vld_cnt = 0; first_cyc = 0; last_cyc = 0; n_first = 0; n_last = 0;
    coincide = 0; rd_cnt = 0; addr_err = 0;
    popped.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_valid = 1'b0; clr_addr = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    mon_addr = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_mem_rd"},     32'(mem_rd),      32'd0);
    chk({tag, "_pe_vld"},     32'(pe_vld),      32'd0);
    chk({tag, "_pe_ctl"},     32'(pe_ctl),      32'd0);
    chk({tag, "_res_valid"},  32'(res_valid),   32'd0);
    chk({tag, "_res_data"},   res_data,         32'd0);
    chk({tag, "_busy"},       32'(busy),        32'd0);
    chk({tag, "_err"},        32'(err),         32'd0);
    chk({tag, "_naddr"},      32'(neuron_addr), 32'd0);
    chk({tag, "_waddr"},      32'(weight_addr), 32'd0);
    chk({tag, "_inst_ready"}, 32'(inst_ready),  32'd1);
    step();
  endtask

  // Holds inst_valid high until one handshake completes; leaves inst_valid asserted.
  task automatic issue(input logic [7:0] len);
    int   k;
    logic hs;
    k = 0; hs = 1'b0;
    inst_valid = 1'b1;
    inst_len   = len;
    while (!hs && k < 70000) begin
      @(negedge clk);
      hs = inst_ready;
      step();
      k++;
    end
    if (!hs) chk("accept_timeout", 32'(hs), 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < max) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    step();
  endtask

  typedef struct {
    logic [7:0]  len;
    int          beats;
    int          last_idx;
    int          nres;
    logic [31:0] res;
    logic [1:0]  err;
  } vec_t;

  vec_t              vec[4];
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W-1:0] arr[32];
  int                acc;

  initial begin
    vec[0] = '{len: 8'd1, beats: 32, last_idx: 31, nres: 1, res: 32'h0000_1234, err: 2'b00};
    vec[1] = '{len: 8'd2, beats: 64, last_idx: 63, nres: 1, res: 32'h0000_5678, err: 2'b00};
    vec[2] = '{len: 8'd3, beats: 96, last_idx: 95, nres: 1, res: 32'hCAFE_0003, err: 2'b00};
    vec[3] = '{len: 8'd0, beats: 0,  last_idx: 0,  nres: 0, res: 32'h0000_0000, err: 2'b01};

    do_reset();
    chk_reset_state("rst0");

    // Table-driven single instructions; addresses persist between them
    exp_addr  = '0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      pe_next_res = vec[i].res;
      issue(vec[i].len);
      inst_valid = 1'b0;
      chk($sformatf("v%0d_busy_after_accept", i), 32'(busy), 32'(vec[i].len != 8'd0));
      wait_idle(400);
      step();
      exp_addr = exp_addr + ADDR_W'(vec[i].beats);
      chk($sformatf("v%0d_rd_cnt", i),  32'(rd_cnt),  32'(vec[i].beats));
      chk($sformatf("v%0d_vld_cnt", i), 32'(vld_cnt), 32'(vec[i].beats));
      chk($sformatf("v%0d_n_last", i), 32'(n_last), 32'(vec[i].nres));
      if (vec[i].beats != 0) begin
        chk($sformatf("v%0d_first_pos", i), 32'(first_pos[0]), 32'd0);
        chk($sformatf("v%0d_last_pos", i),  32'(last_pos[0]),  32'(vec[i].last_idx));
      end
      chk($sformatf("v%0d_n_res", i), 32'(popped.size()), 32'(vec[i].nres));
      if (vec[i].nres != 0 && popped.size() != 0)
        chk($sformatf("v%0d_res", i), popped[0], vec[i].res);
      chk($sformatf("v%0d_err", i),      32'(err),         32'(vec[i].err));
      chk($sformatf("v%0d_addr_seq", i), 32'(addr_err),    32'd0);
      chk($sformatf("v%0d_naddr", i),    32'(neuron_addr), 32'(exp_addr));
    end

    do_reset();
    chk_reset_state("rst1");

    // Back-to-back 2,1,3,1
    clear_mon();
    pe_next_res = 32'h0000_00A0;
    res_ready   = 1'b1;
    issue(8'd2); issue(8'd1); issue(8'd3); issue(8'd1);
    inst_valid = 1'b0;
    wait_idle(600);
    chk("b2b_vld_cnt",    32'(vld_cnt), 32'd224);
    chk("b2b_contiguous", 32'(last_cyc - first_cyc + 1), 32'd224);
    chk("b2b_n_last",     32'(n_last), 32'd4);
    chk("b2b_last0", 32'(last_pos[0]), 32'd63);
    chk("b2b_last1", 32'(last_pos[1]), 32'd95);
    chk("b2b_last2", 32'(last_pos[2]), 32'd191);
    chk("b2b_last3", 32'(last_pos[3]), 32'd223);
    chk("b2b_first1", 32'(first_pos[1]), 32'd64);
    chk("b2b_first3", 32'(first_pos[3]), 32'd192);
    chk("b2b_coincide", 32'(coincide), 32'd0);
    chk("b2b_n_res", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk($sformatf("b2b_res%0d", i), popped[i], 32'h0000_00A0 + 32'(i));
    chk("b2b_naddr", 32'(neuron_addr), 32'd224);
    chk("b2b_waddr", 32'(weight_addr), 32'd224);
    chk("b2b_addr_seq", 32'(addr_err), 32'd0);

    // Credits: six offers with no pops, only RES_DEPTH accepted
    do_reset();
    clear_mon();
    pe_next_res = 32'h0000_00B0;
    res_ready   = 1'b0;
    inst_len    = 8'd1;
    inst_valid  = 1'b1;
    acc = 0;
    repeat (400) begin
      @(negedge clk);
      if (inst_valid && inst_ready) acc++;
      step();
      if (acc == 6) inst_valid = 1'b0;
    end
    inst_valid = 1'b0;
    @(negedge clk);
    chk("credit_accepted", 32'(acc), 32'd4);
    chk("credit_ready_low", 32'(inst_ready), 32'd0);
    chk("credit_res_valid", 32'(res_valid), 32'd1);
    step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    @(negedge clk);
    chk("credit_ready_back", 32'(inst_ready), 32'd1);
    chk("credit_err", 32'(err), 32'd0);
    step();
    res_ready = 1'b1;
    wait_idle(50);
    chk("credit_n_res", 32'(popped.size()), 32'd4);
    if (popped.size() == 4) begin
      chk("credit_res0", popped[0], 32'h0000_00B0);
      chk("credit_res3", popped[3], 32'h0000_00B3);
    end

    // Address wrap: 2047 blocks bring the counters to 0xFFE0
    do_reset();
    clear_mon();
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(8'd255);
    issue(8'd7);
    inst_valid = 1'b0;
    wait_idle(70000);
    chk("wrap_start", 32'(neuron_addr), 32'h0000_FFE0);
    issue(8'd1);
    inst_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      arr[i] = neuron_addr;
      step();
      clr_addr = (i == 4);
    end
    clr_addr = 1'b0;
    wait_idle(50);
    chk("wrap_beat16", 32'(arr[16]), 32'h0000_FFF0);
    chk("wrap_beat31", 32'(arr[31]), 32'h0000_FFFF);
    chk("wrap_naddr",  32'(neuron_addr), 32'd0);
    chk("wrap_waddr",  32'(weight_addr), 32'd0);
    chk("wrap_addr_seq", 32'(addr_err), 32'd0);

    // clr_addr in IDLE
    issue(8'd1);
    inst_valid = 1'b0;
    wait_idle(50);
    chk("clr_pre", 32'(neuron_addr), 32'd32);
    clr_addr = 1'b1;
    step();
    clr_addr = 1'b0;
    mon_addr = '0;
    @(negedge clk);
    chk("clr_naddr", 32'(neuron_addr), 32'd0);
    chk("clr_waddr", 32'(weight_addr), 32'd0);
    step();

    // Reset at beat 10 with a result waiting in the FIFO
    res_ready   = 1'b0;
    pe_next_res = 32'h0000_00C0;
    issue(8'd1);
    inst_valid = 1'b0;
    acc = 0;
    while (!res_valid && acc < 100) begin
      step();
      acc++;
    end
    chk("mid_res_pending", 32'(res_valid), 32'd1);
    issue(8'd2);
    inst_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mid_mem_rd",     32'(mem_rd),      32'd0);
    chk("mid_pe_vld",     32'(pe_vld),      32'd0);
    chk("mid_res_valid",  32'(res_valid),   32'd0);
    chk("mid_inst_ready", 32'(inst_ready),  32'd1);
    chk("mid_naddr",      32'(neuron_addr), 32'd0);
    chk("mid_waddr",      32'(weight_addr), 32'd0);
    step();
    rst = 1'b0;
    mon_addr = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
